// File: rtl/cam_pkg.sv
// Shared constants, types and helpers for the bilinear interpolator.
// Define CAM_BILINEAR_ROUND_EN for round-half-up; the default build truncates.
package cam_pkg;
  localparam int P_DEPTH    = 10;
  localparam int SHIFT_BITS = 10;
  localparam int CHANNELS   = 3;
  localparam int USER_W     = 2;
  localparam int STAGES     = 4;
  localparam int SCALE      = 1 << SHIFT_BITS;
  localparam int H_W        = P_DEPTH + SHIFT_BITS;
  localparam int V_W        = P_DEPTH + 2*SHIFT_BITS;
  // Weights are one bit wider than dx/dy so SCALE-0 is representable.
  localparam int W_W        = SHIFT_BITS + 1;

`ifdef CAM_BILINEAR_ROUND_EN
  localparam logic [V_W-1:0] RND = V_W'(1) << (2*SHIFT_BITS-1);
`else
  localparam logic [V_W-1:0] RND = '0;
`endif

  typedef logic [CHANNELS-1:0][P_DEPTH-1:0] pix_t;
  typedef logic [W_W-1:0]                   wgt_t;

  typedef struct packed {
    pix_t a0, a1, b0, b1;
    wgt_t dx, ndx, dy, ndy;
  } s1_t;

  function automatic wgt_t inv_w(input logic [SHIFT_BITS-1:0] f);
    return W_W'(SCALE) - W_W'(f);
  endfunction
endpackage

// File: rtl/cam_bilinear_mc_if.sv
// Pixel-in / pixel-out valid-ready bus of the bilinear interpolator.
interface cam_bilinear_mc_if;
  import cam_pkg::*;
  logic                           in_valid, in_ready;
  logic [CHANNELS*P_DEPTH-1:0]    in_a0, in_a1, in_b0, in_b1;
  logic [SHIFT_BITS-1:0]          in_dx, in_dy;
  logic [USER_W-1:0]              in_user;
  logic                           out_valid, out_ready;
  logic [CHANNELS*P_DEPTH-1:0]    out_c;
  logic [USER_W-1:0]              out_user;

  modport slave (
    input  in_valid, in_a0, in_a1, in_b0, in_b1, in_dx, in_dy, in_user, out_ready,
    output in_ready, out_valid, out_c, out_user
  );
  modport master (
    output in_valid, in_a0, in_a1, in_b0, in_b1, in_dx, in_dy, in_user, out_ready,
    input  in_ready, out_valid, out_c, out_user
  );
endinterface

// File: rtl/cam_bilinear_lane.sv
// One channel of the S2-S4 datapath: horizontal blend, vertical products, round/shift.
module cam_bilinear_lane
  import cam_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [P_DEPTH-1:0] a0, a1, b0, b1,
  input  wgt_t               dx, ndx, dy, ndy,
  output logic [P_DEPTH-1:0] c
);
  logic [H_W-1:0] ha, hb;
  logic [V_W-1:0] va, vb;
  wgt_t           dy2, ndy2;

  // Each blend sum is bounded by (2^P_DEPTH-1)*SCALE, so the H_W/V_W widths are exact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ha   <= '0;
      hb   <= '0;
      dy2  <= '0;
      ndy2 <= '0;
      va   <= '0;
      vb   <= '0;
      c    <= '0;
    end else if (en) begin
      ha   <= H_W'(a0) * H_W'(ndx) + H_W'(a1) * H_W'(dx);
      hb   <= H_W'(b0) * H_W'(ndx) + H_W'(b1) * H_W'(dx);
      dy2  <= dy;
      ndy2 <= ndy;
      va   <= V_W'(ha) * V_W'(ndy2);
      vb   <= V_W'(hb) * V_W'(dy2);
      c    <= P_DEPTH'((va + vb + RND) >> (2*SHIFT_BITS));
    end
  end
endmodule

// File: rtl/cam_bilinear_mc.sv
// Multi-channel bilinear interpolator, 4-stage pipeline with global stall.
// Rounding mode selected by CAM_BILINEAR_ROUND_EN (see cam_pkg).
module cam_bilinear_mc
  import cam_pkg::*;
(
  input  logic             p_clk,
  input  logic             rst,
  cam_bilinear_mc_if.slave bus
);
  logic                          advance;
  logic [STAGES:1]               vld_pipe;
  logic [STAGES:1][USER_W-1:0]   user_pipe;
  s1_t                           s1;
  pix_t                          out_c;

  // The whole pipe freezes only when the output register holds a pixel nobody takes.
  assign advance       = bus.out_ready | ~vld_pipe[STAGES];
  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out_user  = user_pipe[STAGES];
  assign bus.out_c     = out_c;

  always_ff @(posedge p_clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      user_pipe <= '0;
      s1        <= '0;
    end else if (advance) begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], bus.in_valid};
      user_pipe <= {user_pipe[STAGES-1:1], bus.in_user};
      s1        <= '{a0:  pix_t'(bus.in_a0), a1: pix_t'(bus.in_a1),
                     b0:  pix_t'(bus.in_b0), b1: pix_t'(bus.in_b1),
                     dx:  wgt_t'(bus.in_dx), ndx: inv_w(bus.in_dx),
                     dy:  wgt_t'(bus.in_dy), ndy: inv_w(bus.in_dy)};
    end
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lane
    cam_bilinear_lane u_lane (
      .clk (p_clk),
      .rst (rst),
      .en  (advance),
      .a0  (s1.a0[ch]),
      .a1  (s1.a1[ch]),
      .b0  (s1.b0[ch]),
      .b1  (s1.b1[ch]),
      .dx  (s1.dx),
      .ndx (s1.ndx),
      .dy  (s1.dy),
      .ndy (s1.ndy),
      .c   (out_c[ch])
    );
  end
endmodule

// File: tb/tb_cam_bilinear_mc.sv
// Directed bench for cam_bilinear_mc: corners, rounding, backpressure, sideband, reset.
module tb_cam_bilinear_mc;
  import cam_pkg::*;

  logic p_clk, rst;
  int   n_chk = 0, n_err = 0;

  cam_bilinear_mc_if bus();
  cam_bilinear_mc dut (.p_clk(p_clk), .rst(rst), .bus(bus.slave));

  initial begin
    p_clk = 0;
    forever #5 p_clk = ~p_clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic pix_t px(input int c0, input int c1, input int c2);
    pix_t p;
    p[0] = c0[P_DEPTH-1:0];
    p[1] = c1[P_DEPTH-1:0];
    p[2] = c2[P_DEPTH-1:0];
    return p;
  endfunction

  task automatic drive(input pix_t a0, a1, b0, b1, input int dx, dy, input logic [1:0] u);
    bus.in_a0 = a0; bus.in_a1 = a1; bus.in_b0 = b0; bus.in_b1 = b1;
    bus.in_dx = dx[SHIFT_BITS-1:0]; bus.in_dy = dy[SHIFT_BITS-1:0];
    bus.in_user = u;
  endtask

  // Called #1 after a rising edge with the pipe empty; accept edge is E0, result after E3.
  task automatic run_px(input string tag, input pix_t a0, a1, b0, b1,
                        input int dx, dy, input logic [1:0] u, input pix_t exp);
    bus.out_ready = 1;
    drive(a0, a1, b0, b1, dx, dy, u);
    bus.in_valid = 1;
    #1 check({tag, "_rdy"}, 32'(bus.in_ready), 1);
    @(posedge p_clk); #1 bus.in_valid = 0;
    repeat (2) @(posedge p_clk);
    #1 check({tag, "_early"}, 32'(bus.out_valid), 0);
    @(posedge p_clk); #1;
    check({tag, "_vld"}, 32'(bus.out_valid), 1);
    check({tag, "_c"}, 32'(bus.out_c), 32'(exp));
    check({tag, "_user"}, 32'(bus.out_user), 32'(u));
    @(posedge p_clk); #1 check({tag, "_once"}, 32'(bus.out_valid), 0);
  endtask

  pix_t exp_q[8];
  logic [1:0] user_q[8];

  initial begin
    int ii, oi, cnt;
    logic rdy, held_v;
    logic [31:0] held_c;
    pix_t z, f;
    int rexp;

    z = '0;
    f = px(1023, 1023, 1023);
    rst = 1;
    bus.in_valid = 0; bus.out_ready = 1;
    drive(z, z, z, z, 0, 0, 2'b00);
    repeat (2) @(posedge p_clk);
    #1;
    check("rst_vld",   32'(bus.out_valid), 0);
    check("rst_c",     32'(bus.out_c), 0);
    check("rst_user",  32'(bus.out_user), 0);
    check("rst_ready", 32'(bus.in_ready), 1);
    @(negedge p_clk) rst = 0;
    @(posedge p_clk); #1;

    run_px("corner", px(100, 200, 300), z, z, z, 0, 0, 2'b01, px(100, 200, 300));
`ifdef CAM_BILINEAR_ROUND_EN
    rexp = 512;
`else
    rexp = 511;
`endif
    run_px("round", z, f, z, f, 512, 512, 2'b10, px(rexp, rexp, rexp));
    run_px("full", f, f, f, f, 1023, 1023, 2'b11, f);
    // dx=512: midpoint of 100/200, 10/30, 1000/0
    run_px("hmid", px(100, 10, 1000), px(200, 30, 0), z, z, 512, 0, 2'b00, px(150, 20, 500));
    // dy=256 blends a quarter of the bottom row: 1000/4, 400/4, 8/4
    run_px("vq", z, z, px(1000, 400, 8), z, 0, 256, 2'b01, px(250, 100, 2));

    // Backpressure: 8 pixels, out_ready low in cycles 3..5 after the first accept edge.
    for (int i = 0; i < 8; i++) begin
      exp_q[i]  = px(i*100 + 1, i*100 + 2, i*100 + 3);
      user_q[i] = (i == 0) ? 2'b01 : (i == 7) ? 2'b10 : 2'b00;
    end
    ii = 0; oi = 0; held_v = 0; held_c = 0;
    bus.out_ready = 1;
    drive(exp_q[0], z, z, z, 0, 0, user_q[0]);
    bus.in_valid = 1;
    for (int j = 0; j < 24; j++) begin
      @(negedge p_clk);
      rdy = bus.in_ready;
      check("bp_ready", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
      if (held_v) check("bp_hold", 32'(bus.out_c), held_c);
      held_v = bus.out_valid && !bus.out_ready;
      held_c = 32'(bus.out_c);
      if (bus.out_valid && bus.out_ready) begin
        if (oi < 8) begin
          check("bp_c", 32'(bus.out_c), 32'(exp_q[oi]));
          check("bp_user", 32'(bus.out_user), 32'(user_q[oi]));
        end
        oi++;
      end
      @(posedge p_clk);
      if (bus.in_valid && rdy) ii++;
      #1;
      if (ii < 8) drive(exp_q[ii], z, z, z, 0, 0, user_q[ii]);
      else bus.in_valid = 0;
      bus.out_ready = !(j >= 3 && j <= 5);
    end
    check("bp_in_cnt", 32'(ii), 8);
    check("bp_out_cnt", 32'(oi), 8);

    // Reset mid-stream: 4 accepted, pixel 0 at the output, 3 still in flight.
    bus.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      drive(px(7, 8, 9), z, z, z, 0, 0, 2'b11);
      bus.in_valid = 1;
      @(posedge p_clk); #1;
    end
    bus.in_valid = 0;
    check("mid_pre_vld", 32'(bus.out_valid), 1);
    rst = 1;
    #1;
    check("mid_rst_vld", 32'(bus.out_valid), 0);
    check("mid_rst_c", 32'(bus.out_c), 0);
    check("mid_rst_ready", 32'(bus.in_ready), 1);
    @(posedge p_clk);
    @(negedge p_clk) rst = 0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge p_clk); #1;
      if (bus.out_valid) cnt++;
    end
    check("mid_no_stale", 32'(cnt), 0);
    run_px("mid_new", px(321, 654, 987), z, z, z, 0, 0, 2'b10, px(321, 654, 987));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/cam_bilinear_mc.md
# cam_bilinear_mc

Multi-channel, backpressure-aware bilinear interpolator for the camera scaling path. For each of CHANNELS packed colour components it blends a 2×2 neighbourhood (a0 a1 / b0 b1) with fractional weights dx, dy in fixed point and returns one pixel per accepted input. It sits between the line-buffer window fetch and the scaler output FIFO, replacing the single-channel, free-running interpolator. It adds valid/ready flow control, a sideband pass-through and exact full-width arithmetic.

## Interface
- P_DEPTH, 10: bits per channel sample.
- SHIFT_BITS, 10: fractional bits of dx/dy; SCALE = 2^SHIFT_BITS.
- CHANNELS, 3: channels packed per pixel, channel 0 at LSBs.
- USER_W, 2: sideband width (e.g. sof/eol), carried with the pixel.

Ports:
- p_clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept this cycle.
- in_a0, in_a1, in_b0, in_b1  in  CHANNELS*P_DEPTH  neighbourhood samples.
- in_dx, in_dy  in  SHIFT_BITS  fractional position, 0..SCALE-1.
- in_user  in  USER_W  sideband.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_c  out  CHANNELS*P_DEPTH  interpolated pixel.
- out_user  out  USER_W  sideband aligned with out_c.

## Operation
- Per channel: h_a = a0*(SCALE-dx) + a1*dx; h_b = b0*(SCALE-dx) + b1*dx (width P_DEPTH+SHIFT_BITS); v = h_a*(SCALE-dy) + h_b*dy (width P_DEPTH+2*SHIFT_BITS); out = (v + R) >> 2*SHIFT_BITS.
- R is 2^(2*SHIFT_BITS-1) with rounding enabled, otherwise 0.
- No intermediate truncation. Weights sum to SCALE², so the result is ≤ 2^P_DEPTH-1 and never overflows. No saturation logic.
- Pipeline: S1 register inputs and compute SCALE-dx, SCALE-dy. S2 horizontal products and sums. S3 vertical products. S4 sum, round, shift into the output register.
- Each stage holds a valid bit. user and valid travel with the data.
- Flow control: advance = out_ready | ~out_valid. When advance=0, every stage holds. in_ready = advance (combinational from out_ready).
- Transfers: input on in_valid & in_ready; output on out_valid & out_ready.
- Bubbles: stages with valid=0 may be overwritten while the pipeline is stalled only if no valid data is lost. The required minimum is a global stall (no bubble collapsing).
- Out-of-range dx/dy cannot occur because the ports are SHIFT_BITS wide. dx=0 selects the a0/b0 column exactly.

## Timing
- Latency: 4 p_clk from input transfer to out_valid, with no stall. Throughput is 1 pixel/cycle with out_ready held high.
- Stall of N cycles adds exactly N cycles of latency. No data is dropped or duplicated, and order is preserved.
- Reset (async assert, sync-safe deassert by the system): all stage valids = 0, out_valid = 0, out_c = 0, out_user = 0, in_ready = 1.
- Reset mid-stream discards all in-flight pixels. The first output after reset is the first pixel accepted after reset.
- out_c/out_user stay stable while out_valid=1 and out_ready=0.
- Simultaneous output transfer and input transfer in the same cycle is legal and required for full rate.

## Configuration
- CAM_BILINEAR_ROUND_EN defined: R = 2^(2*SHIFT_BITS-1), giving round half up.
- Not defined: R = 0, truncation. This reproduces the legacy floor behaviour.

## Structure
- Shared package cam_pkg: SCALE computation, width constants (H_W = P_DEPTH+SHIFT_BITS, V_W = P_DEPTH+2*SHIFT_BITS), and the rounding constant selected by the macro.
- One sub-module, cam_bilinear_lane: per-channel datapath for S2–S4 without control, instantiated CHANNELS times in a generate loop.
- Top level owns valids, user pipeline, stall/ready and S1.

## Test plan
(P_DEPTH=10, SHIFT_BITS=10, CHANNELS=3 unless stated.)
- Corner: dx=dy=0, a0=(100,200,300), others 0 → out_c=(100,200,300) at cycle 4 after accept.
- Rounding: a0=b0=0, a1=b1=1023 all channels, dx=dy=512 → 512 with CAM_BILINEAR_ROUND_EN, 511 without.
- Full scale: all samples 1023, dx=dy=1023 → 1023 on every channel, no wrap.
- Backpressure: 8 back-to-back pixels with distinct a0 and dx=dy=0, out_ready low cycles 3–5 → all 8 delivered in order, out_c held stable during the stall, in_ready low exactly while out_valid & ~out_ready.
- Sideband: in_user=2'b01 on first pixel, 2'b10 on last → same values on out_user aligned to those pixels.
- Reset mid-stream: assert rst with 3 pixels in flight → out_valid=0 immediately. After release, only new pixels appear, with latency 4.
